// File: rtl/chess_pkg.sv
// Shared chess constants, FSM state encoding and small board/cursor helpers.
package chess_pkg;

  localparam int SQ_W      = 6;
  localparam int PIECE_W   = 4;
  localparam logic [PIECE_W-1:0] EMPTY = 4'd0;
  localparam int COLOR_BIT = 3;
  localparam int AXIS_W    = 3;
  localparam int BOARD_W   = 64 * PIECE_W;

  typedef enum logic [1:0] {
    CURSOR   = 2'd0,
    SELECTED = 2'd1,
    REQUEST  = 2'd2
  } fsmState_t;

  // Piece code stored on square sq of the packed board word.
  function automatic logic [PIECE_W-1:0] pieceAt(input logic [BOARD_W-1:0] brd,
                                                 input logic [SQ_W-1:0] sq);
    return brd[sq*PIECE_W +: PIECE_W];
  endfunction

  // True when the square holds a piece belonging to the side to move.
  function automatic logic isOwn(input logic [PIECE_W-1:0] code, input logic side);
    return (code != EMPTY) && (code[COLOR_BIT] == side);
  endfunction

  // One step along a single board axis, either wrapping or clamping at the edges.
  function automatic logic [AXIS_W-1:0] stepAxis(input logic [AXIS_W-1:0] pos,
                                                 input logic inc,
                                                 input logic wrap,
                                                 input logic [AXIS_W-1:0] maxPos);
    logic [AXIS_W-1:0] res;
    if (inc) begin
      if (pos == maxPos) res = wrap ? 3'd0 : pos;
      else               res = pos + 3'd1;
    end else begin
      if (pos == 3'd0) res = wrap ? maxPos : pos;
      else             res = pos - 3'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level; history presets high on
// reset so a button held through reset release never fires.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic pulse
);

  logic levelQ_r;
  logic hist_r;

  // Register the level and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      levelQ_r <= 1'b1;
      hist_r   <= 1'b1;
    end else begin
      levelQ_r <= level;
      hist_r   <= levelQ_r;
    end
  end

  assign pulse = levelQ_r & ~hist_r;

endmodule

// File: rtl/move_input_fsm.sv
// Cursor/selection front end for a chess board: buttons move a cursor,
// C selects a source then a destination and raises a move request.
module move_input_fsm
  import chess_pkg::*;
#(
  parameter int WRAP = 1,
  parameter int DIM  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 BTNU,
  input  logic                 BTND,
  input  logic                 BTNL,
  input  logic                 BTNR,
  input  logic                 BTNC,
  input  logic [BOARD_W-1:0]   board,
  input  logic                 turn,
  output logic                 move_valid,
  input  logic                 move_ready,
  output logic [SQ_W-1:0]      move_src,
  output logic [SQ_W-1:0]      move_dst,
  output logic [2*SQ_W:0]      moveData
);

  localparam logic              WRAP_EN  = (WRAP != 0);
  localparam logic [AXIS_W-1:0] AXIS_MAX = 3'(DIM - 1);

  logic evU_s, evD_s, evL_s, evR_s, evC_s;

  btn_edge uEdgeU (.clk(clk), .reset(reset), .level(BTNU), .pulse(evU_s));
  btn_edge uEdgeD (.clk(clk), .reset(reset), .level(BTND), .pulse(evD_s));
  btn_edge uEdgeL (.clk(clk), .reset(reset), .level(BTNL), .pulse(evL_s));
  btn_edge uEdgeR (.clk(clk), .reset(reset), .level(BTNR), .pulse(evR_s));
  btn_edge uEdgeC (.clk(clk), .reset(reset), .level(BTNC), .pulse(evC_s));

  fsmState_t         state_r, stateNext_s;
  logic [AXIS_W-1:0] row_r, col_r, rowNext_s, colNext_s;
  logic [SQ_W-1:0]   src_r, dst_r, srcNext_s, dstNext_s;
  logic [SQ_W-1:0]   curSq_s;
  logic              own_s;

  assign curSq_s  = {row_r, col_r};
  assign own_s    = isOwn(pieceAt(board, curSq_s), turn);
  assign move_src = src_r;
  assign move_dst = dst_r;

  // Next state: C acts on the pre-step cursor and beats any direction; U>D>L>R.
  always_comb begin
    stateNext_s = state_r;
    rowNext_s   = row_r;
    colNext_s   = col_r;
    srcNext_s   = src_r;
    dstNext_s   = dst_r;
    case (state_r)
      REQUEST: begin
        if (move_ready) stateNext_s = CURSOR;
        else            stateNext_s = REQUEST;
      end
      CURSOR, SELECTED: begin
        if (evC_s) begin
          if (state_r == CURSOR) begin
            if (own_s) begin
              srcNext_s   = curSq_s;
              stateNext_s = SELECTED;
            end else begin
              stateNext_s = CURSOR;
            end
          end else if (curSq_s == src_r) begin
            stateNext_s = CURSOR;
          end else if (own_s) begin
            srcNext_s   = curSq_s;
            stateNext_s = SELECTED;
          end else begin
            dstNext_s   = curSq_s;
            stateNext_s = REQUEST;
          end
        end else if (evU_s) begin
          rowNext_s = stepAxis(row_r, 1'b0, WRAP_EN, AXIS_MAX);
        end else if (evD_s) begin
          rowNext_s = stepAxis(row_r, 1'b1, WRAP_EN, AXIS_MAX);
        end else if (evL_s) begin
          colNext_s = stepAxis(col_r, 1'b0, WRAP_EN, AXIS_MAX);
        end else if (evR_s) begin
          colNext_s = stepAxis(col_r, 1'b1, WRAP_EN, AXIS_MAX);
        end else begin
          stateNext_s = state_r;
        end
      end
      default: stateNext_s = CURSOR;
    endcase
  end

  // State, cursor, squares and all outputs are registered from the next values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= CURSOR;
      row_r      <= 3'd0;
      col_r      <= 3'd0;
      src_r      <= 6'd0;
      dst_r      <= 6'd0;
      move_valid <= 1'b0;
      moveData   <= 13'd0;
    end else begin
      state_r    <= stateNext_s;
      row_r      <= rowNext_s;
      col_r      <= colNext_s;
      src_r      <= srcNext_s;
      dst_r      <= dstNext_s;
      move_valid <= (stateNext_s == REQUEST);
      moveData   <= {(stateNext_s != CURSOR), srcNext_s, rowNext_s, colNext_s};
    end
  end

endmodule

// File: tb/tb_move_input_fsm.sv
// Bench for move_input_fsm: one wrapping and one saturating instance share
// stimulus; a square/row/col reference model predicts both.
module tb_move_input_fsm;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         BTNU = 1'b0, BTND = 1'b0, BTNL = 1'b0, BTNR = 1'b0, BTNC = 1'b0;
  logic [255:0] board = 256'd0;
  logic         turn = 1'b0;
  logic         move_ready = 1'b0;

  logic         valid1, valid0;
  logic [5:0]   src1, dst1, src0, dst0;
  logic [12:0]  data1, data0;

  int checks = 0;
  int errors = 0;

  // Reference model, index 1 = wrapping instance, index 0 = saturating one.
  // mode: 0 browsing, 1 piece chosen, 2 request outstanding.
  int mRow[2], mCol[2], mMode[2], mSrc[2], mDst[2];

  typedef struct {
    logic [4:0]  btn;      // {U,D,L,R,C}
    logic [12:0] expData;
    logic        expValid;
  } vec_t;
  vec_t vecs[14];

  localparam logic [4:0] B_U = 5'b10000;
  localparam logic [4:0] B_D = 5'b01000;
  localparam logic [4:0] B_L = 5'b00100;
  localparam logic [4:0] B_R = 5'b00010;
  localparam logic [4:0] B_C = 5'b00001;

  always #5 clk = ~clk;

  move_input_fsm #(.WRAP(1), .DIM(8)) dutWrap (
    .clk(clk), .reset(reset), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .BTNC(BTNC), .board(board), .turn(turn), .move_valid(valid1),
    .move_ready(move_ready), .move_src(src1), .move_dst(dst1), .moveData(data1));

  move_input_fsm #(.WRAP(0), .DIM(8)) dutSat (
    .clk(clk), .reset(reset), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .BTNC(BTNC), .board(board), .turn(turn), .move_valid(valid0),
    .move_ready(move_ready), .move_src(src0), .move_dst(dst0), .moveData(data0));

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int w = 0; w < 2; w++) begin
      mRow[w] = 0; mCol[w] = 0; mMode[w] = 0; mSrc[w] = 0; mDst[w] = 0;
    end
  endtask

  function automatic int stepDec(input int p, input int wrap);
    if (wrap != 0) return (p + 7) % 8;
    else           return (p == 0) ? 0 : p - 1;
  endfunction

  function automatic int stepInc(input int p, input int wrap);
    if (wrap != 0) return (p + 1) % 8;
    else           return (p == 7) ? 7 : p + 1;
  endfunction

  task automatic modelPress(input logic [4:0] b);
    for (int w = 0; w < 2; w++) begin
      int sq;
      logic [3:0] code;
      bit own;
      sq = mRow[w] * 8 + mCol[w];
      code = board[sq*4 +: 4];
      own = (code != 4'd0) && (code[3] == turn);
      if (mMode[w] == 2) begin
        // buttons ignored while a request is outstanding
      end else if (b[0]) begin
        if (mMode[w] == 0) begin
          if (own) begin mSrc[w] = sq; mMode[w] = 1; end
        end else if (sq == mSrc[w]) begin
          mMode[w] = 0;
        end else if (own) begin
          mSrc[w] = sq;
        end else begin
          mDst[w] = sq; mMode[w] = 2;
        end
      end else if (b[4]) mRow[w] = stepDec(mRow[w], w);
      else if (b[3])     mRow[w] = stepInc(mRow[w], w);
      else if (b[2])     mCol[w] = stepDec(mCol[w], w);
      else if (b[1])     mCol[w] = stepInc(mCol[w], w);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int w = 0; w < 2; w++) begin
      logic [12:0] e;
      int sq;
      sq = mRow[w] * 8 + mCol[w];
      e[12]   = (mMode[w] != 0);
      e[11:6] = mSrc[w][5:0];
      e[5:0]  = sq[5:0];
      cmp({tag, w ? " data(wrap)" : " data(sat)"}, w ? data1 : data0, e);
      cmp({tag, w ? " valid(wrap)" : " valid(sat)"}, w ? valid1 : valid0, (mMode[w] == 2));
      cmp({tag, w ? " src(wrap)" : " src(sat)"}, w ? src1 : src0, mSrc[w][5:0]);
      cmp({tag, w ? " dst(wrap)" : " dst(sat)"}, w ? dst1 : dst0, mDst[w][5:0]);
    end
  endtask

  task automatic press(input logic [4:0] b);
    @(negedge clk);
    {BTNU, BTND, BTNL, BTNR, BTNC} = b;
    @(negedge clk);
    {BTNU, BTND, BTNL, BTNR, BTNC} = 5'b00000;
    modelPress(b);
    repeat (2) @(negedge clk);
  endtask

  task automatic ack();
    @(negedge clk);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    for (int w = 0; w < 2; w++) if (mMode[w] == 2) mMode[w] = 0;
    @(negedge clk);
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic loadFixedBoard();
    board = 256'd0;
    board[13*4 +: 4] = 4'h1;
    turn = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{B_R, 13'd1,    1'b0};
    vecs[1]  = '{B_R, 13'd2,    1'b0};
    vecs[2]  = '{B_R, 13'd3,    1'b0};
    vecs[3]  = '{B_D, 13'd11,   1'b0};
    vecs[4]  = '{B_D, 13'd19,   1'b0};
    vecs[5]  = '{B_C, 13'd19,   1'b0};
    vecs[6]  = '{B_U, 13'd11,   1'b0};
    vecs[7]  = '{B_L, 13'd10,   1'b0};
    vecs[8]  = '{B_R, 13'd11,   1'b0};
    vecs[9]  = '{B_R, 13'd12,   1'b0};
    vecs[10] = '{B_R, 13'd13,   1'b0};
    vecs[11] = '{B_C, 13'd4941, 1'b0};
    vecs[12] = '{B_U, 13'd4933, 1'b0};
    vecs[13] = '{B_C, 13'd4933, 1'b1};

    loadFixedBoard();
    modelReset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    cmp("reset data", data1, 13'd0);
    cmp("reset valid", valid1, 1'b0);
    checkAll("reset");

    for (int i = 0; i < 14; i++) begin
      press(vecs[i].btn);
      cmp($sformatf("vec%0d data", i), data1, vecs[i].expData);
      cmp($sformatf("vec%0d valid", i), valid1, vecs[i].expValid);
      checkAll($sformatf("vec%0d", i));
    end

    // Request held stable while not acknowledged.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("hold valid", valid1, 1'b1);
      cmp("hold src", src1, 6'd13);
      cmp("hold dst", dst1, 6'd5);
    end
    press(B_U);
    checkAll("frozen in request");

    // Acknowledge: the very next cycle is idle.
    @(negedge clk);
    move_ready = 1'b1;
    @(negedge clk);
    move_ready = 1'b0;
    cmp("ack valid", valid1, 1'b0);
    cmp("ack data", data1, 13'd837);
    for (int w = 0; w < 2; w++) if (mMode[w] == 2) mMode[w] = 0;
    @(negedge clk);
    checkAll("after ack");
    ack();
    checkAll("ready while idle");

    // Cursor moves exactly one cycle after the press event.
    @(negedge clk);
    BTNR = 1'b1;
    @(negedge clk);
    cmp("step not early", data1[5:0], 6'd5);
    @(negedge clk);
    BTNR = 1'b0;
    cmp("step on time", data1[5:0], 6'd6);
    modelPress(B_R);
    repeat (2) @(negedge clk);
    checkAll("timed step");

    // Button held through reset release gives no step.
    BTNR = 1'b1;
    doReset();
    repeat (3) @(negedge clk);
    BTNR = 1'b0;
    repeat (2) @(negedge clk);
    checkAll("held through reset");

    press(B_U);
    cmp("wrap up", data1[5:0], 6'd56);
    cmp("sat up", data0[5:0], 6'd0);
    press(B_U | B_R);
    cmp("u+r wrap", data1, 13'd48);
    cmp("u+r sat", data0, 13'd0);
    checkAll("priority");

    // Cancel and empty-square C.
    loadFixedBoard();
    doReset();
    press(B_D);
    for (int i = 0; i < 5; i++) press(B_R);
    press(B_C);
    cmp("select 13", data1, 13'd4941);
    press(B_C);
    cmp("cancel", data1, 13'd845);
    press(B_L);
    press(B_C);
    cmp("c on empty", data1, 13'd844);
    checkAll("cancel");

    // Reset while the request is pending drops valid without a clock edge.
    press(B_R);
    press(B_C);
    press(B_R);
    press(B_C);
    cmp("req before reset", valid1, 1'b1);
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    cmp("async drop wrap", valid1, 1'b0);
    cmp("async drop sat", valid0, 1'b0);
    modelReset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkAll("after async reset");

    // Randomised phase against the model.
    for (int n = 0; n < 400; n++) begin
      int r;
      if ($urandom_range(0, 9) == 0) begin
        for (int sq = 0; sq < 64; sq++) begin
          if ($urandom_range(0, 1) == 0) board[sq*4 +: 4] = 4'd0;
          else board[sq*4 +: 4] = 4'($urandom_range(1, 15));
        end
        turn = 1'($urandom_range(0, 1));
      end
      r = $urandom_range(0, 9);
      if (r < 2) begin
        ack();
      end else if (r < 8) begin
        logic [4:0] one;
        one = 5'b00001 << $urandom_range(0, 4);
        press(one);
      end else begin
        press(5'($urandom_range(0, 31)));
      end
      checkAll($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/move_input_fsm.md
MOVE_INPUT_FSM -- requirements
Module: move_input_fsm

Interface
REQ-001 The block SHALL have parameter WRAP, default 1, meaning cursor wraps at board edges (1) or saturates (0).
REQ-002 The block SHALL have parameter DIM, default 8, meaning squares per board side; only the value 8 is supported.
REQ-003 The ports SHALL be: clk  in  1  game clock; the only clock.
REQ-004 The ports SHALL be: reset  in  1  asynchronous, active-high reset.
REQ-005 The ports SHALL be: BTNU, BTND, BTNL, BTNR, BTNC  in  1 each  debounced button levels, synchronous to clk.
REQ-006 The ports SHALL be: board  in  256  64 squares x 4-bit piece code; square i is bits [4i+3:4i]; code 0 is empty; bit 3 of the code is piece colour.
REQ-007 The ports SHALL be: turn  in  1  side to move (0 white, 1 black).
REQ-008 The ports SHALL be: move_valid  out  1  move request to board logic.
REQ-009 The ports SHALL be: move_ready  in  1  board logic accepts the request.
REQ-010 The ports SHALL be: move_src, move_dst  out  6 each  square indices, index = row*8+col.
REQ-011 The ports SHALL be: moveData  out  13  display word: [12] selected flag, [11:6] source square, [5:0] cursor square.

Function
REQ-012 Each button SHALL produce a one-cycle press event on a 0->1 transition of its registered level; a level that stays high SHALL NOT produce further events.
REQ-013 A press event on U/D/L/R SHALL update the cursor one cycle after the event.
- U decrements row; D increments row; L decrements col; R increments col.
REQ-014 With WRAP=1, a cursor step past an edge SHALL wrap modulo 8 on that axis only.
- Example: from col 7, R gives col 0 in the same row.
REQ-015 With WRAP=0, a cursor step past an edge SHALL leave the cursor unchanged.
REQ-016 Simultaneous direction events SHALL be resolved by priority U > D > L > R; only the highest-priority direction SHALL be applied.
REQ-017 When a C event and a direction event occur in the same cycle, the C event SHALL act on the pre-step cursor and the direction event SHALL be discarded.
REQ-018 The FSM SHALL have three states: CURSOR, SELECTED and REQUEST.
REQ-019 In CURSOR, a C event on an own piece (code != 0 and code[3] == turn) SHALL load src = cursor and move to SELECTED.
REQ-020 In CURSOR, a C event on any other square SHALL be ignored.
REQ-021 In SELECTED, a C event SHALL act on the cursor square as follows:
- cursor == src: return to CURSOR (cancel).
- another own piece: src = cursor, stay in SELECTED (reselect).
- any other square: dst = cursor, move to REQUEST.
REQ-022 On entry to REQUEST, move_valid SHALL assert on the cycle after the C event.
REQ-023 While move_valid is high, move_src and move_dst SHALL be held stable.
REQ-024 move_valid SHALL remain high until a rising clk edge samples move_ready = 1; the next cycle SHALL have move_valid = 0, state CURSOR and moveData[12] = 0.
REQ-025 move_ready sampled while move_valid = 0 SHALL be ignored.
REQ-026 In REQUEST, all button events SHALL be discarded and the cursor SHALL be frozen.
REQ-027 moveData[12] SHALL be 1 in SELECTED and REQUEST, and 0 in CURSOR.
REQ-028 moveData[11:6] SHALL equal src, and moveData[5:0] SHALL equal the cursor.
REQ-029 All outputs SHALL be registered.
REQ-030 The board and turn inputs SHALL be sampled only on the cycle a C event is evaluated.

Reset
REQ-031 Reset SHALL force: state = CURSOR, cursor = 0, src = 0, dst = 0, move_valid = 0, moveData = 0.
REQ-032 Reset SHALL preset the button history registers to 1, so a button held through reset release produces no event.
REQ-033 Reset asserted during REQUEST SHALL drop move_valid asynchronously with no acknowledge required.

Structure
REQ-034 A shared package chess_pkg SHALL hold the following constants:
- SQ_W = 6.
- PIECE_W = 4.
- EMPTY = 4'd0.
- COLOR_BIT = 3.
- the state encoding.
REQ-035 The board-sharing logic and the display painter SHALL use chess_pkg.
REQ-036 A single sub-module btn_edge (level in, one-cycle pulse out, async reset presets history to 1) SHALL be instantiated five times.

Verification
REQ-037 Scenario: reset; press R 3 times, then D 2 times -> moveData[5:0] = 19, moveData[12] = 0.
REQ-038 Scenario: WRAP=1, cursor 0; press U -> cursor 56. WRAP=0, cursor 0; press U -> cursor stays 0.
REQ-039 Scenario: turn = 0, board[55:52] = 4'h1, cursor 13; press C -> SELECTED, moveData = {1, 6'd13, 6'd13}.
REQ-040 Scenario: continue from REQ-039; press U -> cursor 5; press C -> move_valid = 1 with src = 13, dst = 5; hold move_ready = 0 for 5 cycles -> valid and payload stable; pulse move_ready -> next cycle move_valid = 0 and state CURSOR.
REQ-041 Scenario: in SELECTED with src = 13; press C on 13 -> CURSOR and moveData[12] = 0. Press C on an empty square while in CURSOR -> no state change.
REQ-042 Scenario: hold BTNR high across reset release -> no cursor step. U and R rise in the same cycle -> only the row changes. Assert reset while move_valid = 1 -> move_valid = 0 immediately.
